// File: rtl/hub_sched_pkg.sv
// Shared types and helpers for the programmable hub-slot scheduler.
package hub_sched_pkg;

    localparam int NUMCOGS_MAX = 8;

    // Scheduling policy; raw mode 3 is reserved and decodes to LEGACY.
    typedef enum logic [1:0] {
        LEGACY    = 2'd0,
        SKIP_IDLE = 2'd1,
        TABLE     = 2'd2
    } sched_mode_e;

    // Commit handshake state.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } commit_state_e;

    // One slot-table entry.
    typedef struct packed {
        logic       valid;
        logic [2:0] cog;
    } slot_entry_t;

    // Mode/length configuration word, laid out like the cfg write data.
    typedef struct packed {
        logic [3:0]  len_m1;
        sched_mode_e mode;
    } cfg_t;

    // Result of a circular search over the cog-enable mask.
    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } srch_t;

    // Map the raw 2-bit mode field onto the mode enum (reserved -> LEGACY).
    function automatic sched_mode_e decode_mode(input logic [1:0] raw);
        sched_mode_e m;
        case (raw)
            2'd1:    m = SKIP_IDLE;
            2'd2:    m = TABLE;
            default: m = LEGACY;
        endcase
        return m;
    endfunction

    // First set bit of mask strictly after base, wrapping; base itself is
    // the last candidate. base=7 therefore searches 0..7 in order.
    function automatic srch_t first_set_after(input logic [7:0] mask,
                                              input logic [2:0] base);
        srch_t      r;
        logic [2:0] pos;
        logic       hit;
        r.found = 1'b0;
        r.idx   = 3'd0;
        for (int k = 1; k <= NUMCOGS_MAX; k++) begin
            pos     = base + 3'(k);
            hit     = !r.found && mask[pos];
            r.idx   = hit ? pos : r.idx;
            r.found = r.found | mask[pos];
        end
        return r;
    endfunction

    // One-hot grant for a cog index, masked to the cogs that exist.
    function automatic logic [7:0] cog_onehot(input logic       vld,
                                              input logic [2:0] idx,
                                              input logic [7:0] present);
        logic [7:0] oh;
        oh = 8'd1 << idx;
        return vld ? (oh & present) : 8'd0;
    endfunction

endpackage

// File: rtl/hub_slot_sched_if.sv
// Configuration and grant signals between the top level and the scheduler.
interface hub_slot_sched_if;
    logic [7:0] cog_ena;
    logic       tbl_w;
    logic [3:0] tbl_a;
    logic [3:0] tbl_d;
    logic       cfg_w;
    logic [5:0] cfg_d;
    logic       commit;
    logic       ena_bus;
    logic [7:0] bus_sel;
    logic [3:0] slot_ptr;
    logic       frame;
    logic       pending;

    // Top level / hub side: drives configuration, observes grants.
    modport master (
        output cog_ena, tbl_w, tbl_a, tbl_d, cfg_w, cfg_d, commit,
        input  ena_bus, bus_sel, slot_ptr, frame, pending
    );

    // Scheduler side.
    modport slave (
        input  cog_ena, tbl_w, tbl_a, tbl_d, cfg_w, cfg_d, commit,
        output ena_bus, bus_sel, slot_ptr, frame, pending
    );
endinterface

// File: rtl/hub_sched_table.sv
// Shadow and active slot tables. Writes only touch the shadow copy; the
// whole shadow array is copied into the active array on apply.
module hub_sched_table
    import hub_sched_pkg::*;
#(
    parameter int TBL_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          wr_en_i,
    input  logic [3:0]                    wr_addr_i,
    input  slot_entry_t                   wr_data_i,
    input  logic                          apply_i,
    output slot_entry_t [TBL_DEPTH-1:0]   shd_o,
    output slot_entry_t [TBL_DEPTH-1:0]   act_o
);

    slot_entry_t [TBL_DEPTH-1:0] shd_q, shd_d;
    slot_entry_t [TBL_DEPTH-1:0] act_q, act_d;

    // Shadow write decode: one entry per write strobe, out-of-range ignored.
    always_comb begin
        shd_d = shd_q;
        for (int i = 0; i < TBL_DEPTH; i++) begin
            if (wr_en_i && (wr_addr_i == 4'(i))) begin
                shd_d[i] = wr_data_i;
            end else begin
                shd_d[i] = shd_q[i];
            end
        end
    end

    // Active table takes the complete shadow image on apply.
    always_comb begin
        if (apply_i) begin
            act_d = shd_q;
        end else begin
            act_d = act_q;
        end
    end

    // Table storage registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shd_q <= '0;
            act_q <= '0;
        end else begin
            shd_q <= shd_d;
            act_q <= act_d;
        end
    end

    assign shd_o = shd_q;
    assign act_o = act_q;

endmodule

// File: rtl/hub_slot_sched.sv
// Programmable hub-slot scheduler: bus phase toggle, per-mode grant
// sequencing (legacy rotation, skip-idle rotation, slot table) and a
// shadow/commit path that swaps configuration only at frame boundaries.
module hub_slot_sched
    import hub_sched_pkg::*;
#(
    parameter int NUMCOGS      = 8,
    parameter int TBL_DEPTH    = 16,
    parameter int DEFAULT_MODE = 0
) (
    input  logic           clk_cog,
    input  logic           nres,
    hub_slot_sched_if.slave bus
);

    localparam logic [3:0] LEN_MAX  = 4'(TBL_DEPTH - 1);
    localparam logic [7:0] COG_MASK = 8'((32'd1 << NUMCOGS) - 32'd1);
    localparam sched_mode_e RST_MODE = (DEFAULT_MODE == 1) ? SKIP_IDLE :
                                       (DEFAULT_MODE == 2) ? TABLE : LEGACY;
    localparam cfg_t RST_CFG = '{len_m1: LEN_MAX, mode: RST_MODE};

    // Registered state
    logic          ena_bus_q, ena_bus_d;
    logic [7:0]    bus_sel_q, bus_sel_d;
    logic [3:0]    slot_ptr_q, slot_ptr_d;
    logic          frame_q, frame_d;
    logic          fresh_q, fresh_d;
    logic          cur_vld_q, cur_vld_d;
    logic [2:0]    cur_idx_q, cur_idx_d;
    cfg_t          act_cfg_q, act_cfg_d;
    cfg_t          shd_cfg_q, shd_cfg_d;
    commit_state_e state_q, state_d;

    // Combinational helpers
    logic                         adv_s;
    logic                         bnd_s;
    logic                         apply_s;
    logic                         restart_s;
    logic [7:0]                   en_mask_s;
    srch_t                        sk_norm_s;
    srch_t                        sk_rst_s;
    srch_t                        sk_sel_s;
    sched_mode_e                  eff_mode_s;
    logic [3:0]                   eff_len_s;
    logic                         nxt_vld_s;
    logic [2:0]                   nxt_idx_s;
    logic [3:0]                   nxt_ptr_s;
    slot_entry_t                  ent_s;
    slot_entry_t [TBL_DEPTH-1:0]  shd_tbl_s;
    slot_entry_t [TBL_DEPTH-1:0]  act_tbl_s;

    hub_sched_table #(
        .TBL_DEPTH (TBL_DEPTH)
    ) u_table (
        .clk_i     (clk_cog),
        .rst_n_i   (nres),
        .wr_en_i   (bus.tbl_w),
        .wr_addr_i (bus.tbl_a),
        .wr_data_i (slot_entry_t'(bus.tbl_d)),
        .apply_i   (apply_s),
        .shd_o     (shd_tbl_s),
        .act_o     (act_tbl_s)
    );

    assign adv_s     = ena_bus_q;
    assign en_mask_s = bus.cog_ena & COG_MASK;
    // Continue after the current cog, or scan from bit 0 when idle.
    assign sk_norm_s = first_set_after(en_mask_s, cur_vld_q ? cur_idx_q : 3'd7);
    assign sk_rst_s  = first_set_after(en_mask_s, 3'd7);

    // Frame-boundary detection, always judged against the active config.
    always_comb begin
        bnd_s = 1'b0;
        if (fresh_q) begin
            bnd_s = 1'b1;
        end else begin
            case (act_cfg_q.mode)
                LEGACY:    bnd_s = !cur_vld_q || (cur_idx_q == 3'd7);
                SKIP_IDLE: bnd_s = !cur_vld_q ||
                                   (sk_norm_s.found && (sk_norm_s.idx <= cur_idx_q));
                TABLE:     bnd_s = (slot_ptr_q >= act_cfg_q.len_m1);
                default:   bnd_s = 1'b1;
            endcase
        end
    end

    // An apply always lands on a boundary, so the new config starts its
    // sequence from the idle state just like the first slot after reset.
    assign apply_s    = adv_s && (state_q == ST_PENDING) && bnd_s;
    assign restart_s  = fresh_q || apply_s;
    assign eff_mode_s = apply_s ? shd_cfg_q.mode   : act_cfg_q.mode;
    assign eff_len_s  = apply_s ? shd_cfg_q.len_m1 : act_cfg_q.len_m1;

    // Next grant in the effective mode.
    always_comb begin
        nxt_vld_s = cur_vld_q;
        nxt_idx_s = cur_idx_q;
        nxt_ptr_s = 4'd0;
        ent_s     = '0;
        sk_sel_s  = restart_s ? sk_rst_s : sk_norm_s;
        case (eff_mode_s)
            SKIP_IDLE: begin
                nxt_vld_s = sk_sel_s.found;
                nxt_idx_s = sk_sel_s.idx;
            end
            TABLE: begin
                if (restart_s || (slot_ptr_q >= eff_len_s)) begin
                    nxt_ptr_s = 4'd0;
                end else begin
                    nxt_ptr_s = slot_ptr_q + 4'd1;
                end
                ent_s     = apply_s ? shd_tbl_s[nxt_ptr_s] : act_tbl_s[nxt_ptr_s];
                nxt_vld_s = ent_s.valid;
                nxt_idx_s = ent_s.cog;
            end
            default: begin
                // Legacy rotation: idle -> cog 0, then 1..7 and wrap.
                nxt_vld_s = 1'b1;
                nxt_idx_s = (restart_s || !cur_vld_q) ? 3'd0 : (cur_idx_q + 3'd1);
            end
        endcase
    end

    // Grant/output next state; everything moves only on advance edges.
    always_comb begin
        ena_bus_d  = ~ena_bus_q;
        fresh_d    = fresh_q;
        cur_vld_d  = cur_vld_q;
        cur_idx_d  = cur_idx_q;
        slot_ptr_d = slot_ptr_q;
        bus_sel_d  = bus_sel_q;
        frame_d    = frame_q;
        if (adv_s) begin
            fresh_d    = 1'b0;
            cur_vld_d  = nxt_vld_s;
            cur_idx_d  = nxt_idx_s;
            slot_ptr_d = nxt_ptr_s;
            bus_sel_d  = cog_onehot(nxt_vld_s, nxt_idx_s, COG_MASK);
            frame_d    = bnd_s;
        end else begin
            fresh_d    = fresh_q;
            bus_sel_d  = bus_sel_q;
        end
    end

    // Shadow config writes (length clamped to the table) and active swap.
    always_comb begin
        shd_cfg_d = shd_cfg_q;
        act_cfg_d = act_cfg_q;
        if (bus.cfg_w) begin
            shd_cfg_d.len_m1 = (bus.cfg_d[5:2] > LEN_MAX) ? LEN_MAX : bus.cfg_d[5:2];
            shd_cfg_d.mode   = decode_mode(bus.cfg_d[1:0]);
        end else begin
            shd_cfg_d = shd_cfg_q;
        end
        if (apply_s) begin
            act_cfg_d = shd_cfg_q;
        end else begin
            act_cfg_d = act_cfg_q;
        end
    end

    // Commit FSM: a commit arms PENDING; it clears on the applying advance
    // unless a fresh commit arrives on that same edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.commit) begin
                    state_d = ST_PENDING;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (apply_s && !bus.commit) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PENDING;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            ena_bus_q  <= 1'b0;
            bus_sel_q  <= 8'd0;
            slot_ptr_q <= 4'd0;
            frame_q    <= 1'b0;
            fresh_q    <= 1'b1;
            cur_vld_q  <= 1'b0;
            cur_idx_q  <= 3'd0;
            act_cfg_q  <= RST_CFG;
            shd_cfg_q  <= RST_CFG;
            state_q    <= ST_IDLE;
        end else begin
            ena_bus_q  <= ena_bus_d;
            bus_sel_q  <= bus_sel_d;
            slot_ptr_q <= slot_ptr_d;
            frame_q    <= frame_d;
            fresh_q    <= fresh_d;
            cur_vld_q  <= cur_vld_d;
            cur_idx_q  <= cur_idx_d;
            act_cfg_q  <= act_cfg_d;
            shd_cfg_q  <= shd_cfg_d;
            state_q    <= state_d;
        end
    end

    assign bus.ena_bus  = ena_bus_q;
    assign bus.bus_sel  = bus_sel_q;
    assign bus.slot_ptr = slot_ptr_q;
    assign bus.frame    = frame_q;
    assign bus.pending  = (state_q == ST_PENDING);

endmodule

// File: tb/tb_hub_slot_sched.sv
// Directed bench for hub_slot_sched: u0 has 8 cogs, u1 has 4 cogs.
module tb_hub_slot_sched;

    logic       clk;
    logic       nres;
    int         n_vec;
    int         n_err;
    logic [7:0] e;

    hub_slot_sched_if bus0 ();
    hub_slot_sched_if bus1 ();

    hub_slot_sched #(.NUMCOGS(8), .TBL_DEPTH(16), .DEFAULT_MODE(0)) u0 (
        .clk_cog (clk),
        .nres    (nres),
        .bus     (bus0)
    );

    hub_slot_sched #(.NUMCOGS(4), .TBL_DEPTH(16), .DEFAULT_MODE(0)) u1 (
        .clk_cog (clk),
        .nres    (nres),
        .bus     (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #2;
    endtask

    task automatic slot();
        edge1();
        edge1();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        nres  = 1'b0;
        bus0.cog_ena = 8'd0; bus0.tbl_w = 1'b0; bus0.tbl_a = 4'd0; bus0.tbl_d = 4'd0;
        bus0.cfg_w = 1'b0; bus0.cfg_d = 6'd0; bus0.commit = 1'b0;
        bus1.cog_ena = 8'd0; bus1.tbl_w = 1'b0; bus1.tbl_a = 4'd0; bus1.tbl_d = 4'd0;
        bus1.cfg_w = 1'b0; bus1.cfg_d = 6'd0; bus1.commit = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ena", 8'(bus0.ena_bus), 8'd0);
        chk("rst_sel", bus0.bus_sel, 8'd0);
        chk("rst_ptr", 8'(bus0.slot_ptr), 8'd0);
        chk("rst_frm", 8'(bus0.frame), 8'd0);
        chk("rst_pnd", 8'(bus0.pending), 8'd0);
        nres = 1'b1;

        // Legacy rotation: edge1 only toggles ena_bus, edge2 grants cog 0
        edge1();
        chk("leg_e1_ena", 8'(bus0.ena_bus), 8'd1);
        chk("leg_e1_sel", bus0.bus_sel, 8'd0);
        edge1();
        chk("leg_e2_ena", 8'(bus0.ena_bus), 8'd0);
        chk("leg_e2_sel", bus0.bus_sel, 8'h01);
        chk("leg_e2_frm", 8'(bus0.frame), 8'd1);
        chk("n4_e2_sel", bus1.bus_sel, 8'h01);
        edge1();
        chk("leg_hold_sel", bus0.bus_sel, 8'h01);
        chk("leg_hold_ena", 8'(bus0.ena_bus), 8'd1);
        edge1();
        chk("leg_e4_sel", bus0.bus_sel, 8'h02);
        for (int k = 2; k <= 8; k++) begin
            slot();
            e = 8'd1 << (k % 8);
            chk("leg_sel", bus0.bus_sel, e);
            chk("leg_frm", 8'(bus0.frame), (k % 8 == 0) ? 8'd1 : 8'd0);
            chk("leg_ena", 8'(bus0.ena_bus), 8'd0);
            chk("n4_leg_sel", bus1.bus_sel, (k % 8 < 4) ? e : 8'd0);
        end
        // edge18: u0 holds 01

        // u0: switch to skip-idle (cfg write on the commit edge); u1: table writes
        bus0.cfg_w = 1'b1; bus0.cfg_d = 6'b1111_01; bus0.commit = 1'b1;
        bus1.tbl_w = 1'b1; bus1.tbl_a = 4'd0; bus1.tbl_d = 4'b1110;
        edge1(); // 19
        bus0.cfg_w = 1'b0; bus0.commit = 1'b0;
        chk("sk_pnd_set", 8'(bus0.pending), 8'd1);
        chk("sk_pnd_sel", bus0.bus_sel, 8'h01);
        bus1.tbl_a = 4'd1; bus1.tbl_d = 4'b1010;
        bus1.cfg_w = 1'b1; bus1.cfg_d = 6'b0001_10; bus1.commit = 1'b1;
        bus0.cog_ena = 8'b0010_0101;
        edge1(); // 20
        bus1.tbl_w = 1'b0; bus1.cfg_w = 1'b0; bus1.commit = 1'b0;
        chk("sk_still_leg", bus0.bus_sel, 8'h02);
        chk("n4_pnd_set", 8'(bus1.pending), 8'd1);
        repeat (6) slot(); // 32
        chk("sk_pre_sel", bus0.bus_sel, 8'h80);
        chk("sk_pre_pnd", 8'(bus0.pending), 8'd1);
        chk("n4_pre_sel", bus1.bus_sel, 8'h00);
        chk("n4_pre_pnd", 8'(bus1.pending), 8'd1);
        slot(); // 34
        chk("sk_g1_sel", bus0.bus_sel, 8'h01);
        chk("sk_g1_frm", 8'(bus0.frame), 8'd1);
        chk("sk_g1_pnd", 8'(bus0.pending), 8'd0);
        chk("n4_t0_sel", bus1.bus_sel, 8'h00);
        chk("n4_t0_ptr", 8'(bus1.slot_ptr), 8'd0);
        chk("n4_t0_frm", 8'(bus1.frame), 8'd1);
        chk("n4_t0_pnd", 8'(bus1.pending), 8'd0);
        slot(); // 36
        chk("sk_g2_sel", bus0.bus_sel, 8'h04);
        chk("sk_g2_frm", 8'(bus0.frame), 8'd0);
        chk("n4_t1_sel", bus1.bus_sel, 8'h04);
        chk("n4_t1_ptr", 8'(bus1.slot_ptr), 8'd1);
        slot(); // 38
        chk("sk_g3_sel", bus0.bus_sel, 8'h20);
        chk("n4_t2_sel", bus1.bus_sel, 8'h00);
        chk("n4_t2_frm", 8'(bus1.frame), 8'd1);
        slot(); // 40
        chk("sk_g4_sel", bus0.bus_sel, 8'h01);
        chk("sk_g4_frm", 8'(bus0.frame), 8'd1);

        // cog_ena drops mid-slot: slot completes, then idle
        bus0.cog_ena = 8'd0;
        edge1(); // 41
        chk("sk_off_hold", bus0.bus_sel, 8'h01);
        edge1(); // 42
        chk("sk_off_idle", bus0.bus_sel, 8'h00);

        // Shadow table writes without commit; skip-idle keeps running
        bus0.cog_ena = 8'b0010_0101;
        bus0.tbl_w = 1'b1; bus0.tbl_a = 4'd0; bus0.tbl_d = 4'b1011;
        edge1(); // 43
        bus0.tbl_a = 4'd1; bus0.tbl_d = 4'b0110;
        edge1(); // 44
        chk("sk_idle_sel", bus0.bus_sel, 8'h01);
        chk("sk_idle_frm", 8'(bus0.frame), 8'd1);
        bus0.tbl_a = 4'd2; bus0.tbl_d = 4'b1101;
        edge1(); // 45
        bus0.tbl_w = 1'b0;
        bus0.cfg_w = 1'b1; bus0.cfg_d = 6'b0010_10;
        edge1(); // 46
        bus0.cfg_w = 1'b0;
        chk("shd_nochg_sel", bus0.bus_sel, 8'h04);
        chk("shd_nochg_pnd", 8'(bus0.pending), 8'd0);
        bus0.commit = 1'b1;
        edge1(); // 47, mid-frame commit
        bus0.commit = 1'b0;
        chk("tb_pnd_set", 8'(bus0.pending), 8'd1);
        edge1(); // 48
        chk("tb_pnd_sel", bus0.bus_sel, 8'h20);
        chk("tb_pnd_hold", 8'(bus0.pending), 8'd1);
        slot(); // 50
        chk("tb_s0_sel", bus0.bus_sel, 8'h08);
        chk("tb_s0_ptr", 8'(bus0.slot_ptr), 8'd0);
        chk("tb_s0_frm", 8'(bus0.frame), 8'd1);
        chk("tb_s0_pnd", 8'(bus0.pending), 8'd0);
        slot(); // 52
        chk("tb_s1_sel", bus0.bus_sel, 8'h00);
        chk("tb_s1_ptr", 8'(bus0.slot_ptr), 8'd1);
        chk("tb_s1_frm", 8'(bus0.frame), 8'd0);
        slot(); // 54
        chk("tb_s2_sel", bus0.bus_sel, 8'h20);
        chk("tb_s2_ptr", 8'(bus0.slot_ptr), 8'd2);
        slot(); // 56
        chk("tb_s3_sel", bus0.bus_sel, 8'h08);
        chk("tb_s3_frm", 8'(bus0.frame), 8'd1);
        slot(); // 58
        chk("tb_s4_sel", bus0.bus_sel, 8'h00);

        // Commit exactly on the boundary edge: applied one frame later
        bus0.tbl_w = 1'b1; bus0.tbl_a = 4'd0; bus0.tbl_d = 4'b1001;
        edge1(); // 59
        bus0.tbl_w = 1'b0;
        edge1(); // 60
        chk("cb_s2_sel", bus0.bus_sel, 8'h20);
        edge1(); // 61
        bus0.commit = 1'b1;
        edge1(); // 62, boundary
        bus0.commit = 1'b0;
        chk("cb_old_sel", bus0.bus_sel, 8'h08);
        chk("cb_old_pnd", 8'(bus0.pending), 8'd1);
        slot(); // 64
        chk("cb_s1_pnd", 8'(bus0.pending), 8'd1);
        slot(); // 66
        chk("cb_s2b_sel", bus0.bus_sel, 8'h20);
        slot(); // 68
        chk("cb_new_sel", bus0.bus_sel, 8'h02);
        chk("cb_new_frm", 8'(bus0.frame), 8'd1);
        chk("cb_new_pnd", 8'(bus0.pending), 8'd0);

        // len_m1 = 0: entry 0 every slot, frame every slot
        bus0.cfg_w = 1'b1; bus0.cfg_d = 6'b0000_10; bus0.commit = 1'b1;
        edge1(); // 69
        bus0.cfg_w = 1'b0; bus0.commit = 1'b0;
        edge1(); // 70
        chk("l0_pre_sel", bus0.bus_sel, 8'h00);
        slot(); // 72
        chk("l0_pre2_sel", bus0.bus_sel, 8'h20);
        for (int k = 0; k < 3; k++) begin
            slot(); // 74, 76, 78
            chk("l0_sel", bus0.bus_sel, 8'h02);
            chk("l0_frm", 8'(bus0.frame), 8'd1);
            chk("l0_ptr", 8'(bus0.slot_ptr), 8'd0);
        end

        // Asynchronous reset mid-operation
        nres = 1'b0;
        #1;
        chk("ar_sel", bus0.bus_sel, 8'd0);
        chk("ar_frm", 8'(bus0.frame), 8'd0);
        chk("ar_ptr", 8'(bus0.slot_ptr), 8'd0);
        chk("ar_pnd", 8'(bus0.pending), 8'd0);
        chk("ar_ena", 8'(bus0.ena_bus), 8'd0);
        chk("ar_n4_ptr", 8'(bus1.slot_ptr), 8'd0);
        chk("ar_n4_sel", bus1.bus_sel, 8'd0);
        repeat (2) @(negedge clk);
        nres = 1'b1;
        edge1();
        chk("ar_e1_ena", 8'(bus0.ena_bus), 8'd1);
        chk("ar_e1_sel", bus0.bus_sel, 8'd0);
        edge1();
        chk("ar_e2_sel", bus0.bus_sel, 8'h01);
        chk("ar_e2_frm", 8'(bus0.frame), 8'd1);
        chk("ar_n4_e2", bus1.bus_sel, 8'h01);
        slot();
        chk("ar_e4_sel", bus0.bus_sel, 8'h02);
        chk("ar_e4_frm", 8'(bus0.frame), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
